main_memory_responder: RTL and testbench

Backing-store responder for the cache-line refill/writeback interface. It sits on the far side of the data/instruction cache miss path. It accepts one line-sized read or write request at a time, models a fixed access latency, and returns a line (read) or an acknowledge (write) through a valid/ready handshake. The cache controller drives the stall seen by the pipeline for as long as this block has a request outstanding.

---
 rtl/main_memory_responder_pkg.sv | 20 ++
 rtl/main_memory_responder_if.sv | 27 ++
 rtl/main_memory_responder_line_storage.sv | 32 +++
 rtl/main_memory_responder.sv | 100 ++++++++++
 tb/tb_main_memory_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the cache refill/writeback responder: state encoding and default line geometry.
// The cache controller imports the same package so both ends agree on line layout.
package main_memory_responder_pkg;

  localparam int WORD_W         = 32;
  localparam int DEF_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int line_off_w(input int line_words);
    return $clog2(4 * line_words);
  endfunction

  localparam int DEF_OFF_W = line_off_w(DEF_LINE_WORDS);

endpackage

// File: rtl/main_memory_responder_if.sv
// Request/response handshake bundle between a cache controller (master) and the memory responder (slave).
interface main_memory_responder_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [32*LINE_WORDS-1:0]  req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic                      resp_write;
  logic [32*LINE_WORDS-1:0]  resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_write, resp_rdata
  );

endinterface

// File: rtl/main_memory_responder_line_storage.sv
// Single-port line array: synchronous write, registered read. A write clears the output register so a
// write response carries an all-zero line.
module main_memory_responder_line_storage #(
  parameter int DEPTH_LINES = 1024,
  parameter int LINE_W      = 128,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (en_i) rdata_q <= we_i ? '0 : mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_responder.sv
// Backing-store responder: accepts one line read/write at a time, waits LATENCY cycles, then
// commits/reads the array and holds the response until the requester takes it.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                clk,
  input  logic                reset,
  main_memory_responder_if.slave bus,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count
);

  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int OFF_W  = line_off_w(LINE_WORDS);
  localparam int IDX_W  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                resp_write_q;
  logic [15:0]         rd_cnt_q;
  logic [15:0]         wr_cnt_q;
  logic [15:0]         rd_cnt_d;
  logic [15:0]         wr_cnt_d;
  logic                commit;
  logic                unused_addr;

  // Line-offset and above-depth address bits are dropped, so out-of-range lines alias.
  assign unused_addr = ^bus.req_addr;

  // Gating with reset makes a reset on the final BUSY edge abort the access cleanly.
  assign commit = (state_q == BUSY) && (cnt_q == CNT_W'(1)) && !reset;

  assign rd_cnt_d = rd_cnt_q + 16'd1;
  assign wr_cnt_d = wr_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_write_q <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            idx_q   <= bus.req_addr[OFF_W +: IDX_W];
            wdata_q <= bus.req_wdata;
            cnt_q   <= CNT_W'(LATENCY);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            resp_write_q <= write_q;
            state_q      <= RESP;
            if (write_q) wr_cnt_q <= wr_cnt_d;
            else         rd_cnt_q <= rd_cnt_d;
          end
        end
        RESP: begin
          if (bus.resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  main_memory_responder_line_storage #(
    .DEPTH_LINES (DEPTH_LINES),
    .LINE_W      (LINE_W),
    .IDX_W       (IDX_W)
  ) u_storage (
    .clk     (clk),
    .rst     (reset),
    .en_i    (commit),
    .we_i    (write_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (bus.resp_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_write = resp_write_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed plus randomized bench for main_memory_responder against a line-array reference model.
module tb_main_memory_responder;

  localparam int LW     = 4;
  localparam int AW     = 32;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  main_memory_responder_if #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) bus ();

  main_memory_responder #(
    .LINE_WORDS  (LW),
    .ADDR_WIDTH  (AW),
    .DEPTH_LINES (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  logic [127:0] model [int];
  int rd_exp = 0;
  int wr_exp = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % DEPTH);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [127:0] wd, input int hold);
    int n;
    logic [127:0] exp_data;
    logic [127:0] held;
    bus.resp_ready = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_idle", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
    chk("req_ready_busy", int'(bus.req_ready), 0);
    n = 0;
    while (!bus.resp_valid && n < 50) begin tick(); n++; end
    chk("latency", n, LAT);
    if (w) begin
      model[idx_of(a)] = wd;
      wr_exp++;
      exp_data = '0;
    end else begin
      rd_exp++;
      exp_data = model.exists(idx_of(a)) ? model[idx_of(a)] : 'x;
    end
    chkd("resp_rdata", bus.resp_rdata, exp_data);
    chk("resp_write", int'(bus.resp_write), int'(w));
    chk("rd_count", int'(rd_count), rd_exp);
    chk("wr_count", int'(wr_count), wr_exp);
    held = bus.resp_rdata;
    for (int k = 0; k < hold; k++) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_write = 1'($urandom_range(0, 1));
      bus.req_addr  = $urandom;
      tick();
      chk("hold_resp_valid", int'(bus.resp_valid), 1);
      chk("hold_req_ready", int'(bus.req_ready), 0);
      chkd("hold_rdata", bus.resp_rdata, held);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    chk("done_resp_valid", int'(bus.resp_valid), 0);
    chk("done_req_ready", int'(bus.req_ready), 1);
    chk("done_rd_count", int'(rd_count), rd_exp);
    chk("done_wr_count", int'(wr_count), wr_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [31:0]  addrs [3];
    int           accs [3];
    int           na, nr, seen;
    logic         rb;
    logic [127:0] pend;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    // Reset state.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_resp_write", int'(bus.resp_write), 0);
    chkd("rst_rdata", bus.resp_rdata, '0);
    chk("rst_rd_count", int'(rd_count), 0);
    chk("rst_wr_count", int'(wr_count), 0);

    // Line 0x40 preloaded with AAAA0000..AAAA0003, then read back.
    xact(1'b1, 32'h0000_0400, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 0);
    xact(1'b0, 32'h0000_0400, '0, 0);

    // Offset within the line is ignored.
    xact(1'b1, 32'h0000_0100, {32'h44, 32'h33, 32'h22, 32'h11}, 0);
    xact(1'b0, 32'h0000_010C, '0, 0);

    // Response held for 7 cycles while requests are waved at the block.
    xact(1'b0, 32'h0000_0100, '0, 7);

    // Address beyond the array aliases to line 2.
    d = {$urandom, $urandom, $urandom, $urandom};
    xact(1'b1, 32'h0000_0020, d, 0);
    xact(1'b0, DEPTH * 16 + 32'h20, '0, 0);

    // Randomized traffic over a small set of lines.
    for (int i = 0; i < 4; i++)
      xact(1'b1, 32'h300 + 32'(i * 16), {$urandom, $urandom, $urandom, $urandom}, 0);
    for (int i = 0; i < 10; i++)
      xact(1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 63)),
           {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 2)));

    // Reset two cycles into a write must abort it; req_valid during reset is ignored.
    d = {$urandom, $urandom, $urandom, $urandom};
    xact(1'b1, 32'h0000_0200, d, 0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0200;
    bus.req_wdata = ~d;
    tick();
    bus.req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.req_valid = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    rd_exp = 0;
    wr_exp = 0;
    chk("abort_req_ready", int'(bus.req_ready), 1);
    chk("abort_resp_valid", int'(bus.resp_valid), 0);
    chk("abort_rd_count", int'(rd_count), 0);
    chk("abort_wr_count", int'(wr_count), 0);
    seen = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      if (bus.resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    xact(1'b0, 32'h0000_0200, '0, 0);

    // Three back-to-back reads with resp_ready tied high.
    addrs[0] = 32'h0000_0400;
    addrs[1] = 32'h0000_0100;
    addrs[2] = 32'h0000_0020;
    na = 0;
    nr = 0;
    pend = '0;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = addrs[0];
    for (int c = 0; c < 80 && nr < 3; c++) begin
      rb = bus.req_ready;
      tick();
      if (rb && na < 3) begin
        accs[na] = cyc;
        pend = model[idx_of(addrs[na])];
        na++;
        if (na < 3) bus.req_addr = addrs[na];
        else        bus.req_valid = 1'b0;
      end
      if (bus.resp_valid) begin
        nr++;
        rd_exp++;
        chkd("stream_rdata", bus.resp_rdata, pend);
        chk("stream_rd_count", int'(rd_count), rd_exp);
      end
    end
    bus.req_valid = 1'b0;
    chk("stream_responses", nr, 3);
    if (na == 3) begin
      chk("stream_gap1", accs[1] - accs[0], LAT + 2);
      chk("stream_gap2", accs[2] - accs[1], LAT + 2);
    end else begin
      chk("stream_accepts", na, 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
